// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM encoding, frame-store
// address strides and default parameter values.
package vram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        WR_DATA = 3'd2,
        RD_CMD  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    localparam logic [31:0] VRAM_STRIDE = 32'h0040_0000;
    localparam logic [31:0] LINE_STRIDE = 32'h0000_1000;

    localparam logic [31:0] DEF_VRAM_BASE  = 32'h1000_0000;
    localparam int          DEF_WR_LEN     = 16;
    localparam int          DEF_LINE_WORDS = 640;
    localparam int          DEF_TIMEOUT    = 4096;

    localparam int BEAT_W = 10;

endpackage

// File: rtl/vram_beat_cnt.sv
// Beat and timeout counters for one burst; both restart on the memory
// command acknowledge and saturate instead of wrapping.
module vram_beat_cnt
    import vram_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              run,
    input  logic              beat,
    input  logic [BEAT_W-1:0] len,
    output logic              done,
    output logic              timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [BEAT_W-1:0] beat_reg;
    logic [TW-1:0]     tmo_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_reg <= '0;
            tmo_reg  <= '0;
        end else if (start) begin
            beat_reg <= '0;
            tmo_reg  <= '0;
        end else if (run) begin
            if (beat && beat_reg != '1)
                beat_reg <= beat_reg + BEAT_W'(1);
            if (tmo_reg != TW'(TIMEOUT))
                tmo_reg <= tmo_reg + TW'(1);
        end
    end

    // done fires on the final beat itself so the FSM leaves on the next edge
    assign done    = run && beat && (beat_reg == len - BEAT_W'(1));
    assign timeout = run && (tmo_reg == TW'(TIMEOUT - 1));

endmodule

// File: rtl/vram_arb.sv
// Two-requester arbiter in front of a burst memory port: line writes from the
// input buffer and display-line reads, alternating when both are pending.
module vram_arb
    import vram_pkg::*;
#(
    parameter logic [31:0] VRAM_BASE  = DEF_VRAM_BASE,
    parameter int          WR_LEN     = DEF_WR_LEN,
    parameter int          LINE_WORDS = DEF_LINE_WORDS,
    parameter int          TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        u_wreq,
    output logic        u_wack,
    input  logic [21:0] u_wadr,
    input  logic        u_wr_da_en,
    input  logic [31:0] u_wr_da,
    input  logic        line_req,
    output logic        line_ack,
    input  logic [11:0] line_no,
    input  logic [1:0]  vram_no,
    output logic [31:0] line_data,
    output logic        line_data_en,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [9:0]  m_len,
    input  logic        m_ack,
    output logic [31:0] m_wdata,
    output logic        m_wdata_en,
    input  logic [31:0] m_rdata,
    input  logic        m_rdata_en,
    output logic        busy,
    output logic        err
);

    state_t      state_reg, state_next;
    logic        last_rd_reg;
    logic [31:0] adr_reg;
    logic        u_wack_reg, line_ack_reg;
    logic [31:0] m_wdata_reg, line_data_reg;
    logic        m_wdata_en_reg, line_data_en_reg;
    logic        err_reg;

    logic        grant_wr, grant_rd;
    logic        in_cmd, in_wr_data, in_rd_data, in_data;
    logic        beat, done, timeout;
    logic [BEAT_W-1:0] beat_len;
    logic [31:0] wr_adr, rd_adr;

    assign in_cmd     = (state_reg == WR_CMD) || (state_reg == RD_CMD);
    assign in_wr_data = (state_reg == WR_DATA);
    assign in_rd_data = (state_reg == RD_DATA);
    assign in_data    = in_wr_data || in_rd_data;
    assign beat       = (in_wr_data && u_wr_da_en) || (in_rd_data && m_rdata_en);
    assign beat_len   = in_rd_data ? BEAT_W'(LINE_WORDS) : BEAT_W'(WR_LEN);

    assign wr_adr = VRAM_BASE + {8'd0, u_wadr, 2'b00};
    assign rd_adr = VRAM_BASE + 32'(vram_no) * VRAM_STRIDE + 32'(line_no) * LINE_STRIDE;

    vram_beat_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (in_cmd && m_ack),
        .run     (in_data),
        .beat    (beat),
        .len     (beat_len),
        .done    (done),
        .timeout (timeout)
    );

    always_comb begin
        state_next = state_reg;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_len      = '0;
        case (state_reg)
            IDLE: begin
                // read wins a tie unless the previous grant already went to read
                if (line_req && (!u_wreq || !last_rd_reg)) begin
                    grant_rd   = 1'b1;
                    state_next = RD_CMD;
                end else if (u_wreq) begin
                    grant_wr   = 1'b1;
                    state_next = WR_CMD;
                end
            end
            WR_CMD: begin
                m_req = 1'b1;
                m_we  = 1'b1;
                m_len = BEAT_W'(WR_LEN);
                if (m_ack)
                    state_next = WR_DATA;
            end
            RD_CMD: begin
                m_req = 1'b1;
                m_len = BEAT_W'(LINE_WORDS);
                if (m_ack)
                    state_next = RD_DATA;
            end
            WR_DATA, RD_DATA: begin
                if (done || timeout)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            last_rd_reg      <= 1'b0;
            adr_reg          <= '0;
            u_wack_reg       <= 1'b0;
            line_ack_reg     <= 1'b0;
            m_wdata_reg      <= '0;
            m_wdata_en_reg   <= 1'b0;
            line_data_reg    <= '0;
            line_data_en_reg <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            state_reg    <= state_next;
            u_wack_reg   <= grant_wr;
            line_ack_reg <= grant_rd;
            if (grant_wr) begin
                adr_reg     <= wr_adr;
                last_rd_reg <= 1'b0;
            end else if (grant_rd) begin
                adr_reg     <= rd_adr;
                last_rd_reg <= 1'b1;
            end
            if (in_wr_data)
                m_wdata_reg <= u_wr_da;
            m_wdata_en_reg <= in_wr_data && u_wr_da_en;
            if (in_rd_data)
                line_data_reg <= m_rdata;
            line_data_en_reg <= in_rd_data && m_rdata_en;
            if (in_data && timeout && !done)
                err_reg <= 1'b1;
        end
    end

    assign u_wack       = u_wack_reg;
    assign line_ack     = line_ack_reg;
    assign m_adr        = adr_reg;
    assign m_wdata      = m_wdata_reg;
    assign m_wdata_en   = m_wdata_en_reg;
    assign line_data    = line_data_reg;
    assign line_data_en = line_data_en_reg;
    assign busy         = (state_reg != IDLE);
    assign err          = err_reg;

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: address table, randomized arbitration
// against a request-level model, and hand sequences for stall/timeout/reset.
module tb_vram_arb;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int WLEN = 16;
    localparam int RLEN = 640;
    localparam int TMO  = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        u_wreq = 1'b0, u_wack;
    logic [21:0] u_wadr = '0;
    logic        u_wr_da_en = 1'b0;
    logic [31:0] u_wr_da = '0;
    logic        line_req = 1'b0, line_ack;
    logic [11:0] line_no = '0;
    logic [1:0]  vram_no = '0;
    logic [31:0] line_data;
    logic        line_data_en;
    logic        m_req, m_we;
    logic [31:0] m_adr;
    logic [9:0]  m_len;
    logic        m_ack = 1'b0;
    logic [31:0] m_wdata;
    logic        m_wdata_en;
    logic [31:0] m_rdata = '0;
    logic        m_rdata_en = 1'b0;
    logic        busy, err;

    int n_checks = 0;
    int n_fail   = 0;
    bit last_rd  = 1'b0;

    always #5 clk = ~clk;

    vram_arb dut (
        .clk(clk), .reset_n(reset_n),
        .u_wreq(u_wreq), .u_wack(u_wack), .u_wadr(u_wadr),
        .u_wr_da_en(u_wr_da_en), .u_wr_da(u_wr_da),
        .line_req(line_req), .line_ack(line_ack), .line_no(line_no), .vram_no(vram_no),
        .line_data(line_data), .line_data_en(line_data_en),
        .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_len(m_len), .m_ack(m_ack),
        .m_wdata(m_wdata), .m_wdata_en(m_wdata_en),
        .m_rdata(m_rdata), .m_rdata_en(m_rdata_en),
        .busy(busy), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wr_addr(input logic [21:0] a);
        return BASE + 32'(a) * 4;
    endfunction

    function automatic logic [31:0] rd_addr(input logic [11:0] ln, input logic [1:0] vn);
        return BASE + 32'(vn) * 32'h0040_0000 + 32'(ln) * 32'h1000;
    endfunction

    task automatic zero_outs(input string tag);
        check({tag, "_flags"}, 32'({u_wack, line_ack, line_data_en, m_req, m_we, m_wdata_en, busy, err}), 32'd0);
        check({tag, "_m_adr"}, m_adr, 32'd0);
        check({tag, "_m_len"}, 32'(m_len), 32'd0);
        check({tag, "_data"}, line_data | m_wdata, 32'd0);
    endtask

    task automatic drive(input bit is_rd, input bit en, input logic [31:0] d);
        if (is_rd) begin
            m_rdata_en = en;  m_rdata = d;
            u_wr_da_en = 1'($urandom_range(0, 1));  u_wr_da = ~d;
        end else begin
            u_wr_da_en = en;  u_wr_da = d;
            m_rdata_en = 1'($urandom_range(0, 1));  m_rdata = ~d;
        end
    endtask

    task automatic chk_beat(input bit is_rd, input bit pen, input logic [31:0] pd);
        check(is_rd ? "line_data_en" : "m_wdata_en", 32'(is_rd ? line_data_en : m_wdata_en), 32'(pen));
        if (pen)
            check(is_rd ? "line_data" : "m_wdata", is_rd ? line_data : m_wdata, pd);
        check("gated_en", 32'(is_rd ? m_wdata_en : line_data_en), 32'd0);
        check("ack_low_in_data", 32'(u_wack | line_ack), 32'd0);
    endtask

    // Feeds nbeats with random gaps; every output beat must equal the input one cycle earlier.
    task automatic run_data(input bit is_rd, input int nbeats);
        int sent = 0;
        int cyc = 0;
        bit pen = 1'b0;
        logic [31:0] pd = '0;
        bit en;
        logic [31:0] d;
        while (sent < nbeats && cyc < 4 * nbeats + 20) begin
            @(negedge clk);
            m_ack = 1'b0;
            chk_beat(is_rd, pen, pd);
            en = ($urandom_range(0, 3) != 0);
            d  = $urandom;
            drive(is_rd, en, d);
            pen = en;
            pd  = d;
            if (en) sent++;
            cyc++;
        end
        check("beats_sent", 32'(sent), 32'(nbeats));
        @(negedge clk);
        chk_beat(is_rd, pen, pd);
        m_rdata_en = 1'b0;
        u_wr_da_en = 1'b0;
        check("idle_after_last", 32'(busy), 32'd0);
    endtask

    // Waits for the grant the model predicts, checks the command, then runs the burst.
    task automatic serve(input logic [31:0] exp_wadr, input logic [31:0] exp_radr,
                         input int stall, input bit ghost);
        bit exp_rd;
        bit got = 1'b0;
        int lat = 0;
        bit is_rd;
        exp_rd = line_req && (!u_wreq || !last_rd);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (u_wack || line_ack) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        check("grant_seen", 32'(got), 32'd1);
        if (!got) begin
            u_wreq = 1'b0;
            line_req = 1'b0;
            return;
        end
        is_rd = line_ack;
        check("ack_latency", 32'(lat), 32'd0);
        check("grant_is_read", 32'(is_rd), 32'(exp_rd));
        check("other_ack_low", 32'(is_rd ? u_wack : line_ack), 32'd0);
        check("m_req", 32'(m_req), 32'd1);
        check("m_we", 32'(m_we), 32'(!exp_rd));
        check("m_len", 32'(m_len), exp_rd ? 32'(RLEN) : 32'(WLEN));
        check("m_adr", m_adr, exp_rd ? exp_radr : exp_wadr);
        last_rd = exp_rd;
        if (is_rd) line_req = 1'b0; else u_wreq = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_m_req", 32'(m_req), 32'd1);
            check("stall_m_adr", m_adr, exp_rd ? exp_radr : exp_wadr);
            check("stall_no_data", 32'({line_data_en, m_wdata_en, u_wack, line_ack}), 32'd0);
            m_rdata_en = 1'b1;
            u_wr_da_en = 1'b1;
            if (ghost && s == 10) u_wreq = 1'b1;
            if (ghost && s == 50) u_wreq = 1'b0;
        end
        m_ack = 1'b1;
        run_data(is_rd, is_rd ? RLEN : WLEN);
    endtask

    typedef struct {
        bit          is_rd;
        logic [21:0] wadr;
        logic [11:0] ln;
        logic [1:0]  vn;
        logic [31:0] exp_adr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_idle;
        int nrd;
        logic [1:0] r;

        tbl[0] = '{1'b1, 22'h000000, 12'd2,   2'd1, 32'h1040_2000};
        tbl[1] = '{1'b0, 22'h000010, 12'd0,   2'd0, 32'h1000_0040};
        tbl[2] = '{1'b0, 22'h3FFFFF, 12'd0,   2'd0, 32'h10FF_FFFC};
        tbl[3] = '{1'b1, 22'h000000, 12'hFFF, 2'd3, 32'h11BF_F000};
        tbl[4] = '{1'b1, 22'h000000, 12'd0,   2'd0, 32'h1000_0000};

        repeat (3) @(negedge clk);
        zero_outs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Both requests in the same cycle: read, then write, then read again.
        u_wadr = 22'h000100; line_no = 12'd5; vram_no = 2'd2;
        u_wreq = 1'b1; line_req = 1'b1;
        serve(wr_addr(u_wadr), rd_addr(line_no, vram_no), 0, 1'b0);
        line_req = 1'b1;
        serve(wr_addr(u_wadr), rd_addr(line_no, vram_no), 0, 1'b0);
        serve(wr_addr(u_wadr), rd_addr(line_no, vram_no), 0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].is_rd) begin
                line_no = tbl[i].ln; vram_no = tbl[i].vn; line_req = 1'b1;
            end else begin
                u_wadr = tbl[i].wadr; u_wreq = 1'b1;
            end
            serve(tbl[i].exp_adr, tbl[i].exp_adr, 0, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            r = 2'($urandom_range(1, 3));
            if (r[0] && !u_wreq) begin
                u_wadr = 22'($urandom); u_wreq = 1'b1;
            end
            if (r[1] && !line_req) begin
                line_no = 12'($urandom); vram_no = 2'($urandom); line_req = 1'b1;
            end
            serve(wr_addr(u_wadr), rd_addr(line_no, vram_no), $urandom_range(0, 3), 1'b0);
        end
        for (int j = 0; j < 2 && (u_wreq || line_req); j++)
            serve(wr_addr(u_wadr), rd_addr(line_no, vram_no), 0, 1'b0);
        u_wreq = 1'b0; line_req = 1'b0;

        // 100-cycle command stall; a write request comes and goes without a grant.
        line_no = 12'd7; vram_no = 2'd0; line_req = 1'b1;
        serve(wr_addr(u_wadr), rd_addr(line_no, vram_no), 100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dropped_req_no_ack", 32'({u_wack, busy}), 32'd0);
        end

        // Short read burst: only 10 beats, must time out.
        line_no = 12'd1; vram_no = 2'd0; line_req = 1'b1;
        @(negedge clk);
        check("tmo_line_ack", 32'(line_ack), 32'd1);
        line_req = 1'b0; last_rd = 1'b1; m_ack = 1'b1;
        first_idle = -1; nrd = 0;
        for (int k = 1; k <= TMO + 20; k++) begin
            @(negedge clk);
            m_ack = 1'b0;
            if (line_data_en) nrd++;
            if (k == TMO) begin
                check("err_before_timeout", 32'(err), 32'd0);
                check("busy_before_timeout", 32'(busy), 32'd1);
            end
            m_rdata_en = (k <= 10);
            m_rdata = 32'(k);
            if (!busy) begin
                first_idle = k;
                break;
            end
        end
        m_rdata_en = 1'b0;
        check("timeout_cycle", 32'(first_idle), 32'(TMO + 1));
        check("tmo_beats_fwd", 32'(nrd), 32'd10);
        check("err_set", 32'(err), 32'd1);
        check("busy_after_tmo", 32'(busy), 32'd0);

        u_wadr = 22'h000123; u_wreq = 1'b1;
        serve(wr_addr(u_wadr), 32'd0, 1, 1'b0);
        check("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a read burst.
        line_no = 12'd3; vram_no = 2'd2; line_req = 1'b1;
        @(negedge clk);
        check("rst_line_ack", 32'(line_ack), 32'd1);
        line_req = 1'b0; m_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m_ack = 1'b0;
            m_rdata_en = 1'b1;
            m_rdata = $urandom;
        end
        @(negedge clk);
        check("rst_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        zero_outs("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        last_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'({line_data_en, line_ack, u_wack, busy, m_req}), 32'd0);
        end
        m_rdata_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
